// File: rtl/config_request_initiator.sv
// rtl/config_request_initiator.sv - config-bus master issuing single uncached store/load requests
// Accepts one request at a time, presents it on the config bus and returns exactly one response.
package config_pkg;
  localparam logic T_STORE = 1'b0;
  localparam logic T_LOAD  = 1'b1;
endpackage

module config_request_initiator
  import config_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_load,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_is_load,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  conf_valid,
  output logic                  conf_config_type,
  output logic [ADDR_WIDTH-1:0] conf_addr,
  output logic [DATA_WIDTH-1:0] conf_data,
  input  logic                  conf_read_valid,
  input  logic [DATA_WIDTH-1:0] conf_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_e;

  localparam int unsigned CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(RD_TIMEOUT);

  state_e                state_q, state_d;
  logic                  is_load_q, is_load_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_load_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_load_d  = req_is_load;
          addr_d     = req_addr;
          data_d     = req_data;
          cnt_d      = '0;
          rsp_data_d = '0;
          // Misaligned requests never reach the bus; they are answered with an error.
          if (req_addr[2:0] != 3'b000) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!is_load_q) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          state_d    = RESP;
        end else if (conf_read_valid) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = conf_read_data;
          state_d    = RESP;
        end else begin
          cnt_d   = CW'(1);
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (conf_read_valid) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = conf_read_data;
          state_d    = RESP;
        end else if (cnt_q == TMO) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is a function of registered state only.
  assign req_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign conf_valid       = (state_q == ISSUE) || (state_q == WAIT_RD);
  assign conf_config_type = conf_valid ? is_load_q : T_STORE;
  assign conf_addr        = conf_valid ? addr_q : '0;
  assign conf_data        = conf_valid ? data_q : '0;
  assign rsp_valid        = (state_q == RESP);
  assign rsp_is_load      = rsp_valid ? is_load_q : 1'b0;
  assign rsp_err          = rsp_valid ? rsp_err_q : 1'b0;
  assign rsp_data         = rsp_valid ? rsp_data_q : '0;

endmodule

// File: tb/tb_config_request_initiator.sv
// tb/tb_config_request_initiator.sv - scoreboard bench for config_request_initiator
module tb_config_request_initiator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_load;
  logic [63:0] req_addr, req_data;
  logic        rsp_valid, rsp_ready, rsp_is_load, rsp_err;
  logic [63:0] rsp_data;
  logic        conf_valid, conf_config_type, conf_read_valid;
  logic [63:0] conf_addr, conf_data, conf_read_data;
  logic        busy;

  config_request_initiator #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .RD_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_load(rsp_is_load),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .conf_valid(conf_valid), .conf_config_type(conf_config_type),
    .conf_addr(conf_addr), .conf_data(conf_data),
    .conf_read_valid(conf_read_valid), .conf_read_data(conf_read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [63:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int conf_cycles = 0;
  int n_rsp = 0;
  int pres = 0;
  int slave_delay = 0;
  logic [63:0] slave_data = '0;
  logic        exp_ld = 1'b0;
  logic [63:0] exp_addr = '0;
  logic [63:0] exp_cdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave answers combinationally on the slave_delay-th presented cycle (0 = never).
  assign conf_read_valid = conf_valid && (slave_delay != 0) && (pres + 1 == slave_delay);
  assign conf_read_data  = slave_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n || !conf_valid) pres <= 0;
    else pres <= pres + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (conf_valid) begin
        conf_cycles++;
        check("conf_type", 64'(conf_config_type), 64'(exp_ld));
        check("conf_addr", conf_addr, exp_addr);
        check("conf_data", conf_data, exp_cdata);
      end else begin
        check("conf_idle_zero", conf_addr | conf_data, 64'd0);
      end
      if (rsp_valid) begin
        check("rsp_req_ready_low", 64'(req_ready), 64'd0);
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          check("rsp_is_load", 64'(rsp_is_load), 64'(sb[0].ld));
          check("rsp_data", rsp_data, sb[0].data);
          check("rsp_err", 64'(rsp_err), 64'(sb[0].err));
          if (rsp_ready) begin
            if (sb[0].lat >= 0) check("rsp_latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
            n_rsp++;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic drive_req(input logic ld, input logic [63:0] a, input logic [63:0] d);
    int waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("req_ready_before_req", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_is_load = ld; req_addr = a; req_data = d;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0; req_is_load = 1'b0; req_addr = '0; req_data = '0;
  endtask

  task automatic run_req(input logic ld, input logic [63:0] a, input logic [63:0] d,
                         input int sdly, input logic [63:0] sdata,
                         input logic [63:0] edata, input logic eerr,
                         input int elat, input int econf, input int hold);
    exp_t e;
    int c0;
    slave_delay = sdly; slave_data = sdata;
    exp_ld = ld; exp_addr = a; exp_cdata = d;
    c0 = conf_cycles;
    e.ld = ld; e.data = edata; e.err = eerr; e.lat = elat;
    sb.push_back(e);
    if (hold > 0) rsp_ready = 1'b0;
    drive_req(ld, a, d);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check("rsp_drained", 64'(sb.size()), 64'd0);
    check("conf_len", 64'(conf_cycles - c0), 64'(econf));
    check("req_ready_after_hs", 64'(req_ready), 64'd1);
  endtask

  initial begin
    int c0;
    int r0;
    rst_n = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_outputs", 64'({rsp_valid, rsp_is_load, rsp_err, conf_valid, conf_config_type, busy}), 64'd0);
    check("rst_buses", rsp_data | conf_addr | conf_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // store, slave idle
    run_req(1'b0, 64'h10, 64'hDEAD_BEEF_0000_0001, 0, 64'h0, 64'h0, 1'b0, 1, 1, 0);
    // load answered in the issue cycle
    run_req(1'b1, 64'h8, 64'h0, 1, 64'h1234, 64'h1234, 1'b0, 1, 1, 0);
    // load answered on the third presented cycle
    run_req(1'b1, 64'h18, 64'h77, 3, 64'hABCD, 64'hABCD, 1'b0, 3, 3, 0);
    // load timing out
    run_req(1'b1, 64'h40, 64'h0, 0, 64'h0, 64'h0, 1'b1, 17, 17, 0);
    // misaligned store, then an aligned store with a spurious read_valid from the slave
    run_req(1'b0, 64'h14, 64'h5, 1, 64'hFFFF, 64'h0, 1'b1, 0, 0, 0);
    run_req(1'b0, 64'h20, 64'hCAFE, 1, 64'hFFFF, 64'h0, 1'b0, 1, 1, 0);
    // load with the consumer stalling for 10 cycles
    run_req(1'b1, 64'h30, 64'h0, 1, 64'h5555_AAAA, 64'h5555_AAAA, 1'b0, -1, 1, 10);

    // reset while a load is waiting for read-back
    slave_delay = 0; exp_ld = 1'b1; exp_addr = 64'h28; exp_cdata = 64'h0;
    r0 = n_rsp;
    drive_req(1'b1, 64'h28, 64'h0);
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_conf_valid", 64'(conf_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_conf_valid", 64'(conf_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_outputs", 64'({rsp_valid, busy, conf_config_type}), 64'd0);
    check("midrst_buses", conf_addr | conf_data | rsp_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    c0 = conf_cycles;
    repeat (25) @(posedge clk);
    #1;
    check("no_rsp_after_rst", 64'(n_rsp - r0), 64'd0);
    check("no_conf_after_rst", 64'(conf_cycles - c0), 64'd0);
    check("idle_after_rst", 64'({req_ready, busy}), 64'b10);

    // normal operation resumes
    run_req(1'b0, 64'h48, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 64'h0, 1'b0, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
